// File: rtl/alu_md_unit.sv
// alu_md_unit: WIDTH-bit execute ALU with an iterative radix-2 multiply/divide unit and HI/LO registers.
// Define ALU_DIV_EN to build the divider for DIV/DIVU; without it those ops return illegal in one cycle.
`timescale 1ns/1ps
module alu_md_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             illegal
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W   = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
  localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(WIDTH);

  localparam logic [4:0] OP_ADD   = 5'h00;
  localparam logic [4:0] OP_SUB   = 5'h01;
  localparam logic [4:0] OP_AND   = 5'h03;
  localparam logic [4:0] OP_OR    = 5'h04;
  localparam logic [4:0] OP_XOR   = 5'h05;
  localparam logic [4:0] OP_NOR   = 5'h06;
  localparam logic [4:0] OP_SLTU  = 5'h07;
  localparam logic [4:0] OP_SLT   = 5'h08;
  localparam logic [4:0] OP_SLL   = 5'h09;
  localparam logic [4:0] OP_SRL   = 5'h0A;
  localparam logic [4:0] OP_SRA   = 5'h0B;
  localparam logic [4:0] OP_GTZ   = 5'h0C;
  localparam logic [4:0] OP_MULT  = 5'h10;
  localparam logic [4:0] OP_MULTU = 5'h11;
`ifdef ALU_DIV_EN
  localparam logic [4:0] OP_DIV   = 5'h12;
  localparam logic [4:0] OP_DIVU  = 5'h13;
`endif
  localparam logic [4:0] OP_MFHI  = 5'h14;
  localparam logic [4:0] OP_MFLO  = 5'h15;
  localparam logic [4:0] OP_MTHI  = 5'h16;
  localparam logic [4:0] OP_MTLO  = 5'h17;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   out_r, hi_r, lo_r, acc_hi_r, acc_lo_r, opnd_r;
  logic               zero_r, illegal_r, out_valid_r, neg_q_r;
  logic [CNT_W-1:0]   cnt_r;
`ifdef ALU_DIV_EN
  logic               is_div_r, neg_r_r, div0_r, md_div_s;
  logic [WIDTH:0]     div_sh_s;
  logic [WIDTH-1:0]   div_sub_s;
`endif
  logic [SHAMT_W-1:0] shamt_s;
  logic [WIDTH-1:0]   alu_res_s, step_hi_s, step_lo_s, fin_hi_s, fin_lo_s;
  logic               alu_ill_s, md_start_s, md_signed_s, accept_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] prod_s, prod_fin_s;

  // Operands are converted to magnitudes; the sign is reapplied when the result commits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    if (is_signed && v[WIDTH-1]) begin
      return ZERO_W - v;
    end else begin
      return v;
    end
  endfunction

  assign shamt_s   = in1[SHAMT_W-1:0];
  assign out       = out_r;
  assign zero      = zero_r;
  assign illegal   = illegal_r;
  assign out_valid = out_valid_r;

  // Handshake: accept while idle, or while the current result is being consumed.
  always_comb begin
    in_ready = reset_n & ((state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready));
    accept_s = in_valid & in_ready;
  end

  // Single-cycle ALU result and multiply/divide start decode.
  always_comb begin
    alu_res_s   = ZERO_W;
    alu_ill_s   = 1'b0;
    md_start_s  = 1'b0;
    md_signed_s = 1'b0;
`ifdef ALU_DIV_EN
    md_div_s    = 1'b0;
`endif
    case (op)
      OP_ADD:   alu_res_s = in1 + in2;
      OP_SUB:   alu_res_s = in1 - in2;
      OP_AND:   alu_res_s = in1 & in2;
      OP_OR:    alu_res_s = in1 | in2;
      OP_XOR:   alu_res_s = in1 ^ in2;
      OP_NOR:   alu_res_s = ~(in1 | in2);
      OP_SLTU:  alu_res_s = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      OP_SLT:   alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      OP_SLL:   alu_res_s = in2 << shamt_s;
      OP_SRL:   alu_res_s = in2 >> shamt_s;
      OP_SRA:   alu_res_s = $unsigned($signed(in2) >>> shamt_s);
      OP_GTZ:   alu_res_s = {{(WIDTH-1){1'b0}}, ~in1[WIDTH-1]};
      OP_MULT:  begin md_start_s = 1'b1; md_signed_s = 1'b1; end
      OP_MULTU: md_start_s = 1'b1;
`ifdef ALU_DIV_EN
      OP_DIV:   begin md_start_s = 1'b1; md_signed_s = 1'b1; md_div_s = 1'b1; end
      OP_DIVU:  begin md_start_s = 1'b1; md_div_s = 1'b1; end
`endif
      OP_MFHI:  alu_res_s = hi_r;
      OP_MFLO:  alu_res_s = lo_r;
      OP_MTHI:  alu_res_s = in1;
      OP_MTLO:  alu_res_s = in1;
      default:  alu_ill_s = 1'b1;
    endcase
  end

  // One radix-2 iteration plus the sign-corrected final HI/LO values.
  always_comb begin
    mul_sum_s  = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opnd_r} : {1'b0, ZERO_W});
    step_hi_s  = mul_sum_s[WIDTH:1];
    step_lo_s  = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
    prod_s     = {step_hi_s, step_lo_s};
    prod_fin_s = neg_q_r ? (ZERO_2W - prod_s) : prod_s;
    fin_hi_s   = prod_fin_s[2*WIDTH-1:WIDTH];
    fin_lo_s   = prod_fin_s[WIDTH-1:0];
`ifdef ALU_DIV_EN
    // Restoring division: the remainder never exceeds the divisor, so WIDTH-bit subtraction is exact.
    div_sh_s  = {acc_hi_r, acc_lo_r[WIDTH-1]};
    div_sub_s = div_sh_s[WIDTH-1:0] - opnd_r;
    if (is_div_r) begin
      if (div_sh_s >= {1'b0, opnd_r}) begin
        step_hi_s = div_sub_s;
        step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
      end else begin
        step_hi_s = div_sh_s[WIDTH-1:0];
        step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
      end
      fin_lo_s = div0_r ? ONES_W : (neg_q_r ? (ZERO_W - step_lo_s) : step_lo_s);
      fin_hi_s = neg_r_r ? (ZERO_W - step_hi_s) : step_hi_s;
    end else begin
      fin_hi_s = prod_fin_s[2*WIDTH-1:WIDTH];
      fin_lo_s = prod_fin_s[WIDTH-1:0];
    end
`endif
  end

  // Control FSM, HI/LO and registered result outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      out_r       <= ZERO_W;
      zero_r      <= 1'b1;
      illegal_r   <= 1'b0;
      out_valid_r <= 1'b0;
      hi_r        <= ZERO_W;
      lo_r        <= ZERO_W;
      acc_hi_r    <= ZERO_W;
      acc_lo_r    <= ZERO_W;
      opnd_r      <= ZERO_W;
      cnt_r       <= {CNT_W{1'b0}};
      neg_q_r     <= 1'b0;
`ifdef ALU_DIV_EN
      is_div_r    <= 1'b0;
      neg_r_r     <= 1'b0;
      div0_r      <= 1'b0;
`endif
    end else if (flush) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_BUSY: begin
          acc_hi_r <= step_hi_s;
          acc_lo_r <= step_lo_s;
          cnt_r    <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            hi_r        <= fin_hi_s;
            lo_r        <= fin_lo_s;
            out_r       <= fin_lo_s;
            zero_r      <= (fin_lo_s == ZERO_W);
            illegal_r   <= 1'b0;
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end
        end
        ST_IDLE, ST_DONE: begin
          if (accept_s && md_start_s) begin
            state_r     <= ST_BUSY;
            out_valid_r <= 1'b0;
            cnt_r       <= CNT_FULL;
            acc_hi_r    <= ZERO_W;
            neg_q_r     <= md_signed_s & (in1[WIDTH-1] ^ in2[WIDTH-1]);
`ifdef ALU_DIV_EN
            is_div_r    <= md_div_s;
            neg_r_r     <= md_signed_s & in1[WIDTH-1];
            div0_r      <= (in2 == ZERO_W);
            if (md_div_s) begin
              acc_lo_r <= magnitude(in1, md_signed_s);
              opnd_r   <= magnitude(in2, md_signed_s);
            end else begin
              acc_lo_r <= magnitude(in2, md_signed_s);
              opnd_r   <= magnitude(in1, md_signed_s);
            end
`else
            acc_lo_r    <= magnitude(in2, md_signed_s);
            opnd_r      <= magnitude(in1, md_signed_s);
`endif
          end else if (accept_s) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
            out_r       <= alu_res_s;
            zero_r      <= (alu_res_s == ZERO_W);
            illegal_r   <= alu_ill_s;
            if (op == OP_MTHI) hi_r <= in1;
            if (op == OP_MTLO) lo_r <= in1;
          end else if ((state_r == ST_DONE) && out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end
endmodule
